// File: rtl/adc_reader.sv
// ---------------------------------------------------------------------------
// adc_reader
//
// Serial capture front end for the FFT datapath.  Drives the conversion-start
// line of an ADS7883-style serial ADC and shifts in its MSB-first data stream,
// producing NUM_SAMPLES parallel samples per burst, each tagged with its
// write address in the FFT input buffer.
//
// The ADC shares clk with this block: it changes sd on the falling edge and
// this block samples sd on the rising edge.
//
// Frame timing, c0 = the cycle with cs high:
//   c0           CONV   cs=1, ADC bit counter resets
//   c1           LEAD   leading bit sampled (must be 0)
//   c2..c(W+1)   SHIFT  data bits W-1..0 sampled
//   c(W+2)              sample_valid; next frame's CONV (INTERVAL=0)
//                       or the first GAP cycle (INTERVAL>0)
//
// Handshake: start is a single-cycle request.  It is accepted only while busy
// is low; a start seen while busy (including the FIN cycle) is dropped.
// sample_valid is a one-cycle strobe with no back-pressure: sample_data and
// sample_addr are valid exactly in the cycle it is high.
//
// Ports:
//   clk            system clock, shared with the ADC
//   reset          synchronous, active-high
//   start          one-cycle burst request
//   sd             ADC serial data
//   cs             conversion-start pulse to the ADC, one cycle per frame
//   busy           high from the cycle after an accepted start until done
//   done           one-cycle pulse after the final sample_valid
//   sample_data    last captured sample (unsigned, WIDTH bits)
//   sample_valid   one-cycle strobe qualifying sample_data/sample_addr
//   sample_addr    sample index within the burst, 0..NUM_SAMPLES-1
//   framing_error  sticky: some frame's leading bit was sampled as 1
// ---------------------------------------------------------------------------
module adc_reader #(
    parameter int WIDTH       = 12,
    parameter int NUM_SAMPLES = 128,
    parameter int INTERVAL    = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           sd,
    output logic                           cs,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH-1:0]               sample_data,
    output logic                           sample_valid,
    output logic [$clog2(NUM_SAMPLES)-1:0] sample_addr,
    output logic                           framing_error
);

    localparam int AW = $clog2(NUM_SAMPLES);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(INTERVAL + 2);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_SAMPLES - 1);
    // Unused when INTERVAL=0: GAP is never entered.
    localparam logic [GW-1:0] GAP_LAST  = (INTERVAL > 0) ? GW'(INTERVAL - 1) : '0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CONV  = 3'd1,
        LEAD  = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [AW-1:0]    samp_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             last_bit;
    logic             last_sample;

    assign last_bit    = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign last_sample = (samp_cnt == ADDR_LAST);

    // cs is decoded straight from the state so it can never be high for two
    // cycles in a row: CONV always leaves to LEAD.
    assign cs   = (state == CONV);
    assign busy = (state != IDLE);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = CONV;
            end
            CONV:  state_nxt = LEAD;
            LEAD:  state_nxt = SHIFT;
            SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    if (last_sample)       state_nxt = FIN;
                    else if (INTERVAL > 0) state_nxt = GAP;
                    else                   state_nxt = CONV;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = CONV;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            samp_cnt      <= '0;
            shift_reg     <= '0;
            done          <= 1'b0;
            sample_valid  <= 1'b0;
            sample_data   <= '0;
            sample_addr   <= '0;
            framing_error <= 1'b0;
        end else begin
            state        <= state_nxt;
            // done trails FIN by one cycle so it lands right after the
            // final sample_valid, the same cycle busy drops.
            done         <= (state == FIN);
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        framing_error <= 1'b0;
                        sample_addr   <= '0;
                        samp_cnt      <= '0;
                    end
                end
                CONV: begin
                    bit_cnt <= '0;
                end
                LEAD: begin
                    if (sd) framing_error <= 1'b1;
                end
                SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], sd};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (last_bit) begin
                        sample_data  <= {shift_reg[WIDTH-2:0], sd};
                        sample_valid <= 1'b1;
                        sample_addr  <= samp_cnt;
                        gap_cnt      <= '0;
                        // Saturate rather than wrap inside a burst.
                        if (!last_sample) samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_reader
//
// Two instances share clk/reset/start:
//   dut0: WIDTH=12, NUM_SAMPLES=128, INTERVAL=0  (frame period 14)
//   dut1: WIDTH=12, NUM_SAMPLES=4,   INTERVAL=3  (frame period 17)
// Each has its own ADC model driving sd.  The reference model tracks, per
// instance, the cycle offset r from the accepted start and derives every
// expected output from the burst timing arithmetic.
// ---------------------------------------------------------------------------
module tb_adc_reader;

    localparam int W   = 12;
    localparam int N0  = 128;
    localparam int I0  = 0;
    localparam int N1  = 4;
    localparam int I1  = 3;
    localparam int AW0 = $clog2(N0);
    localparam int AW1 = $clog2(N1);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]     sd = '0;
    logic [1:0]     cs, busy, done, sv, ferr;
    logic [W-1:0]   sdata0, sdata1;
    logic [AW0-1:0] addr0;
    logic [AW1-1:0] addr1;

    adc_reader #(.WIDTH(W), .NUM_SAMPLES(N0), .INTERVAL(I0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .sd(sd[0]),
        .cs(cs[0]), .busy(busy[0]), .done(done[0]),
        .sample_data(sdata0), .sample_valid(sv[0]),
        .sample_addr(addr0), .framing_error(ferr[0])
    );

    adc_reader #(.WIDTH(W), .NUM_SAMPLES(N1), .INTERVAL(I1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .sd(sd[1]),
        .cs(cs[1]), .busy(busy[1]), .done(done[1]),
        .sample_data(sdata1), .sample_valid(sv[1]),
        .sample_addr(addr1), .framing_error(ferr[1])
    );

    // ---------------- scoreboard bookkeeping ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    function automatic int nsm(input int i);   return (i == 0) ? N0 : N1;         endfunction
    function automatic int ivl(input int i);   return (i == 0) ? I0 : I1;         endfunction
    function automatic int per(input int i);   return W + 2 + ivl(i);             endfunction
    function automatic int rdone(input int i); return 2 + nsm(i) * per(i) - ivl(i); endfunction

    // Hand-computed constants pinning the model.
    function automatic int lat_lit(input int i); return (i == 0) ? 1794 : 67; endfunction
    function automatic int gap_lit(input int i); return (i == 0) ? 14 : 17;   endfunction
    function automatic int cnt_lit(input int i); return (i == 0) ? 128 : 4;   endfunction

    // ADC-side queues: words the ADC has sent, in frame order.
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] pre_q[$];      // preloaded words for dut0's ADC

    // ---------------- reference model ----------------
    int  cyc = 0;
    bit  armed = 0;
    bit  act[2];                 // busy per the model
    bit  bv[2];                  // a burst has started since last reset
    int  r[2];                   // cycle offset from the accepted start cycle
    bit  fe_m[2];
    int  ld[2];
    int  la[2];
    int  acc_cyc[2];
    int  vcnt[2];
    int  last_v[2];
    int  done_seen[2];
    bit  prev_cs[2];
    int  pin_idx = 0;
    logic [W-1:0] pins [2];
    bit  force_lead[2];

    initial begin
        pins[0] = 12'hA5C;
        pins[1] = 12'h3F1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; bv[i] = 0; r[i] = 0; fe_m[i] = 0; ld[i] = 0; la[i] = 0;
            acc_cyc[i] = 0; vcnt[i] = 0; last_v[i] = 0; done_seen[i] = 0;
            prev_cs[i] = 0; force_lead[i] = 0;
        end
    end

    function automatic bit is_lead(input int i, input int rr);
        return rr >= 2 && ((rr - 2) % per(i)) == 0 && ((rr - 2) / per(i)) < nsm(i);
    endfunction

    always @(posedge clk) begin
        cyc++;
        armed = 1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                act[i] = 0; bv[i] = 0; fe_m[i] = 0; ld[i] = 0; la[i] = 0; r[i] = 0;
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                if (act[i] && is_lead(i, r[i]) && sd[i]) fe_m[i] = 1;
                if (!act[i] && start) begin
                    act[i] = 1; bv[i] = 1; r[i] = 1; fe_m[i] = 0; la[i] = 0;
                    acc_cyc[i] = cyc - 1;
                    vcnt[i] = 0;
                end else begin
                    if (bv[i]) r[i]++;
                    if (act[i] && r[i] == rdone(i)) act[i] = 0;
                end
            end
        end
    end

    function automatic int get_data(input int i);
        return (i == 0) ? int'(sdata0) : int'(sdata1);
    endfunction

    function automatic int get_addr(input int i);
        return (i == 0) ? int'(addr0) : int'(addr1);
    endfunction

    // ---------------- compare + ADC models (mid-cycle) ----------------
    int           pos[2] = '{W + 1, W + 1};
    logic [W-1:0] cur[2] = '{'0, '0};

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int  rr, p, n;
                bit  e_cs, e_v, e_d;
                rr = r[i]; p = per(i); n = nsm(i);
                e_cs = bv[i] && rr >= 1 && ((rr - 1) % p) == 0 && ((rr - 1) / p) < n;
                e_v  = bv[i] && rr >= W + 3 && ((rr - W - 3) % p) == 0 && ((rr - W - 3) / p) < n;
                e_d  = bv[i] && rr == rdone(i);
                if (e_v) begin
                    la[i] = (rr - W - 3) / p;
                    if (i == 0 ? exp_q0.size() == 0 : exp_q1.size() == 0)
                        check("queue_empty", i, 1, 0);
                    else
                        ld[i] = (i == 0) ? int'(exp_q0.pop_front()) : int'(exp_q1.pop_front());
                end
                check("cs", i, cs[i], e_cs);
                check("cs_double", i, cs[i] & prev_cs[i], 0);
                check("busy", i, busy[i], act[i]);
                check("done", i, done[i], e_d);
                check("sample_valid", i, sv[i], e_v);
                check("sample_data", i, get_data(i), ld[i]);
                check("sample_addr", i, get_addr(i), la[i]);
                check("framing_error", i, ferr[i], fe_m[i]);
                prev_cs[i] = cs[i];

                if (sv[i]) begin
                    if (vcnt[i] > 0) check("valid_spacing", i, cyc - last_v[i], gap_lit(i));
                    if (i == 0 && pin_idx < 2) begin
                        check("pin_data", i, sdata0, pins[pin_idx]);
                        pin_idx++;
                    end
                    last_v[i] = cyc;
                    vcnt[i]++;
                end
                if (done[i]) begin
                    check("burst_latency", i, cyc - acc_cyc[i], lat_lit(i));
                    check("valid_count", i, vcnt[i], cnt_lit(i));
                    if (i == 1 && done_seen[1] == 0) check("ferr_at_done", i, ferr[1], 1);
                    done_seen[i]++;
                end
            end
        end

        // ADC models: cs high resets the bit position and starts a new word.
        for (int i = 0; i < 2; i++) begin
            if (cs[i] === 1'b1) begin
                logic [W-1:0] w;
                if (i == 0 && pre_q.size() > 0) w = pre_q.pop_front();
                else w = W'($urandom_range(0, (1 << W) - 1));
                if (i == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
                cur[i] = w;
                pos[i] = 0;
            end else begin
                if (pos[i] == 0)      sd[i] = force_lead[i];
                else if (pos[i] <= W) sd[i] = cur[i][W - pos[i]];
                else                  sd[i] = cur[i][0];
                if (pos[i] <= W) pos[i]++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (done[0] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 0, n < budget, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        reset = 1'b0;
        cycles(2);

        // Burst A: pinned first words, framing fault on dut1, starts while busy.
        pre_q.push_back(12'hA5C);
        pre_q.push_back(12'h3F1);
        pulse_start();                       // now in r=1
        cycles(19);  force_lead[1] = 1'b1;   // r=20
        cycles(20);  force_lead[1] = 1'b0;   // r=40
        cycles(9);   start = 1'b1;           // r=49, dut0 busy
        cycles(1);   start = 1'b0;           // r=50
        cycles(1743); start = 1'b1;          // r=1793, dut0 in FIN
        cycles(1);   start = 1'b0;           // r=1794
        @(negedge clk);
        check("done_after_fin_start", 0, done[0], 1);
        check("ferr_cleared", 1, ferr[1], 0);
        cycles(80);

        // Burst B: ramp data on dut0.
        for (int k = 0; k < N0; k++) pre_q.push_back(W'(k));
        pulse_start();
        wait_done0(2500);
        cycles(30);

        // Burst C: reset during SHIFT of sample 5, then a clean rerun.
        pulse_start();
        cycles(77);  reset = 1'b1;           // r=78
        cycles(1);   reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 0, busy[0], 0);
        check("post_reset_addr", 0, addr0, 0);
        check("post_reset_data", 0, sdata0, 0);
        cycles(5);
        for (int k = 0; k < 8; k++) pre_q.push_back(W'($urandom_range(0, 4095)));
        pulse_start();
        wait_done0(2500);
        cycles(30);

        check("dut0_done_total", 0, done_seen[0], 3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_reader.md
# adc_reader

Serial capture front end for the FFT datapath. It drives the conversion-start line of the ADS7883-style 12-bit serial ADC and shifts in the MSB-first data stream. It emits NUM_SAMPLES parallel samples, each tagged with a write address for the FFT input buffer, and pulses `done` at the end of the burst. It runs on the same clock as the ADC: the ADC updates `sd` on the falling edge of `clk`, and this block samples `sd` on the rising edge.

## Interface
- `WIDTH`, 12: sample width in bits.
- `NUM_SAMPLES`, 128: samples captured per `start`; power of two, ≥2.
- `INTERVAL`, 0: extra idle cycles, with `cs` low, between frames; sets the sample rate.

Ports:
- `clk`  in  1  system clock; the ADC is clocked by the same `clk`.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request to begin a burst; ignored while `busy`.
- `sd`  in  1  ADC serial data.
- `cs`  out  1  conversion-start/frame pulse to the ADC, one cycle high per frame.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at the end of the burst.
- `sample_data`  out  WIDTH  last captured sample.
- `sample_valid`  out  1  one-cycle strobe; `sample_data` and `sample_addr` are valid in that cycle.
- `sample_addr`  out  $clog2(NUM_SAMPLES)  index of the sample, 0..NUM_SAMPLES-1.
- `framing_error`  out  1  sticky flag: a frame's leading bit was sampled as 1.

## Operation
- **ADC framing.** `cs` high for exactly one cycle resets the ADC's bit counter. While `cs` is low, each falling edge emits:
  - a leading 0;
  - then data bits WIDTH-1 down to 0;
  - then `sd` holds the LSB.
  - A second consecutive high cycle would advance the ADC's sample pointer twice, so `cs` is never high for more than one cycle.
- **States:**
  - IDLE: `cs`=0. On `start` → CONV.
  - CONV: `cs`=1 for one cycle, bit counter cleared. → LEAD.
  - LEAD: sample `sd`; if 1, set `framing_error`. → SHIFT.
  - SHIFT: shift `sd` into the shift register MSB first, for WIDTH cycles. On the last bit:
    - load `sample_data` = {shift[WIDTH-2:0], `sd`} and pulse `sample_valid`;
    - if more samples remain → GAP (INTERVAL>0) or CONV (INTERVAL=0);
    - else → FIN.
  - GAP: `cs`=0 for INTERVAL cycles. → CONV.
  - FIN: pulse `done`, drop `busy`. → IDLE.
- **Addressing.**
  - `sample_addr` = 0 for the first sample of a burst and increments by 1 per `sample_valid`.
  - The internal count saturates at NUM_SAMPLES-1; it never wraps within a burst.
- **Reset values.** `cs`=0, `busy`=0, `done`=0, `sample_valid`=0, `sample_data`=0, `sample_addr`=0, `framing_error`=0, state IDLE.
- **`start` behaviour.**
  - `start` clears `framing_error` and `sample_addr` when accepted.
  - `start` during `busy` (including the FIN cycle) is ignored.
- **Reset mid-burst.** Return immediately to reset values; no `done` pulse. The next `start`'s CONV pulse resynchronises the ADC bit counter.
- **Arithmetic.** `sample_data` is unsigned WIDTH bits. The block does no arithmetic on the data.

## Timing
- Cycle c0 is the cycle in which `cs`=1.
- The leading bit is sampled at the rising edge ending c1. Data bits WIDTH-1..0 are sampled at the edges ending c2..c(WIDTH+1).
- `sample_valid` is high in cycle c(WIDTH+2).
- `cs` first rises in the cycle after `start` is sampled high.
- Frame period = WIDTH+2+INTERVAL cycles. With INTERVAL=0, the next `cs` high coincides with `sample_valid` of the previous frame.
- `done` is high in the cycle after the final `sample_valid`. `busy` is 0 from that same cycle.
- Burst latency, from the `start` cycle to `done`: 1 + NUM_SAMPLES·(WIDTH+2+INTERVAL) − INTERVAL + 1 cycles.

## Test plan
- **Single frame.** NUM_SAMPLES=2, ADC model loaded with 0xA5C, 0x3F1, `start` once → two `sample_valid` strobes:
  - `sample_addr` 0, `sample_data` 0xA5C;
  - then `sample_addr` 1, `sample_data` 0x3F1;
  - `done` 1 cycle later; `framing_error`=0.
- **Full burst.** NUM_SAMPLES=128, model ramp 0..127 → 128 strobes with data == addr, 14 cycles apart, one `done`; `cs` never high for two consecutive cycles.
- **INTERVAL=3.**
  - `sample_valid` strobes are 17 cycles apart.
  - `cs` pulses are 17 cycles apart.
  - `cs` stays low during gaps.
- **Framing error.** Force `sd`=1 during a LEAD cycle → `framing_error` rises and stays high to burst end; the next `start` clears it.
- **Reset mid-frame.** Assert `reset` during SHIFT of sample 5 →
  - next cycle all outputs at reset values;
  - a new `start` yields `sample_addr` 0 with correct data after the model re-runs.
- **Start while busy.** Pulse `start` mid-burst and again in the FIN cycle → burst length unchanged; no extra `cs` pulse; exactly one `done`.
